// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_port_arbiter_if : timing, BRAM and writer signals for fb_port_arbiter   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface fb_port_arbiter_if #(
    parameter int PIX_BITS = 4,
    parameter int ADDR_W   = 18
);
    logic [10:0]           hcount;
    logic [9:0]            vcount;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [4*PIX_BITS-1:0] mem_din;
    logic [4*PIX_BITS-1:0] mem_dout;
    logic                  wr_req;
    logic [ADDR_W-1:0]     wr_addr;
    logic [4*PIX_BITS-1:0] wr_data;
    logic                  wr_ack;
    logic [PIX_BITS-1:0]   pixel;
    logic                  pixel_valid;

    // Arbiter side
    modport slave (
        input  hcount, vcount, mem_dout, wr_req, wr_addr, wr_data,
        output mem_addr, mem_we, mem_din, wr_ack, pixel, pixel_valid
    );

    // Environment side: timing generator, BRAM and pixel writer
    modport master (
        output hcount, vcount, mem_dout, wr_req, wr_addr, wr_data,
        input  mem_addr, mem_we, mem_din, wr_ack, pixel, pixel_valid
    );
endinterface
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_port_arbiter : frame-buffer BRAM port sharing, display reads win,       |
// |                   writer gets spare cycles; unpacks 4 pixels per word      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fb_port_arbiter #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int H_TOTAL  = 1344,
    parameter int V_TOTAL  = 806,
    parameter int PIX_BITS = 4,
    parameter int ADDR_W   = 18
) (
    input  wire logic        vga_clock,
    input  wire logic        reset,
    fb_port_arbiter_if.slave bus
);
    localparam int                WORD_W           = 4 * PIX_BITS;
    localparam logic [ADDR_W-1:0] c_WORDS_PER_LINE = ADDR_W'(H_ACTIVE / 4);

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wstate_t;

    wstate_t                         r_state;
    wstate_t                         w_state_nxt;
    logic                            r_slot_d;
    logic                            r_synced;
    logic [WORD_W-1:0]               r_next_word;
    logic [WORD_W-1:0]               r_cur_word;
    logic [PIX_BITS-1:0]             r_pixel;
    logic                            r_pixel_valid;

    logic [9:0]                      w_line_next;
    logic                            w_slot_grp;
    logic                            w_slot_ls;
    logic                            w_disp_slot;
    logic [ADDR_W-1:0]               w_disp_addr;
    logic                            w_active;
    logic                            w_we;
    logic [ADDR_W-1:0]               w_addr;
    logic [WORD_W-1:0]               w_din;
    logic [3:0][PIX_BITS-1:0]        w_cur_pix;

    // Display slot: fetch the next group mid-line, or the next line's first word in hblank
    always_comb begin
        w_line_next = (bus.vcount == 10'(V_TOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;
        w_slot_grp  = (bus.vcount < 10'(V_ACTIVE)) && (bus.hcount[1:0] == 2'b00) &&
                      (bus.hcount <= 11'(H_ACTIVE - 8));
        w_slot_ls   = (bus.hcount == 11'(H_TOTAL - 4)) && (w_line_next < 10'(V_ACTIVE));
        w_disp_slot = w_slot_grp || w_slot_ls;
        if (w_slot_ls) begin
            w_disp_addr = ADDR_W'(w_line_next) * c_WORDS_PER_LINE;
        end else begin
            w_disp_addr = ADDR_W'(bus.vcount) * c_WORDS_PER_LINE +
                          ADDR_W'(bus.hcount[10:2]) + ADDR_W'(1);
        end
        w_active = (bus.hcount < 11'(H_ACTIVE)) && (bus.vcount < 10'(V_ACTIVE));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_addr      = w_disp_addr;
        w_din       = '0;
        case (r_state)
            W_IDLE: begin
                if (bus.wr_req && !w_disp_slot && !reset) begin
                    w_we        = 1'b1;
                    w_addr      = bus.wr_addr;
                    w_din       = bus.wr_data;
                    w_state_nxt = W_ACK;
                end
            end
            W_ACK:   w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign w_cur_pix = r_cur_word;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_state       <= W_IDLE;
            r_slot_d      <= 1'b0;
            r_synced      <= 1'b0;
            r_next_word   <= '0;
            r_cur_word    <= '0;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot_d <= w_disp_slot;
            if (r_slot_d) begin
                r_next_word <= bus.mem_dout;
            end
            // Until the first line-start load after reset, cur_word holds no valid line
            if (bus.hcount == 11'(H_TOTAL - 1)) begin
                r_cur_word <= r_next_word;
                r_synced   <= 1'b1;
            end else if ((bus.hcount[1:0] == 2'b11) && (bus.hcount < 11'(H_ACTIVE - 1))) begin
                r_cur_word <= r_next_word;
            end
            r_pixel_valid <= w_active;
            r_pixel       <= (w_active && r_synced) ? w_cur_pix[bus.hcount[1:0]] : '0;
        end
    end

    assign bus.mem_addr    = w_addr;
    assign bus.mem_we      = w_we;
    assign bus.mem_din     = w_din;
    assign bus.wr_ack      = (r_state == W_ACK);
    assign bus.pixel       = r_pixel;
    assign bus.pixel_valid = r_pixel_valid;
endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fb_port_arbiter : directed scoreboard bench for fb_port_arbiter         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fb_port_arbiter_if bus ();

    fb_port_arbiter dut (
        .vga_clock (clk),
        .reset     (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // BRAM model, preloaded with word k = k[15:0] on the first edge
    logic [15:0] bram [0:262143];
    bit          init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 262144; k++) bram[k] <= 16'(k);
            init_done <= 1'b1;
        end else if (bus.mem_we) begin
            bram[bus.mem_addr] <= bus.mem_din;
        end
        bus.mem_dout <= bram[bus.mem_addr];
    end

    typedef struct packed {
        logic       v;
        logic [3:0] p;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         errors   = 0;
    int         acks     = 0;
    int         pv_count = 0;
    bit         tb_synced = 1'b0;
    bit         wrote5    = 1'b0;
    logic [3:0] l0_exp [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};

    task automatic chk(string tag, int obs, int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] gold(int k);
        return (wrote5 && k == 5) ? 16'hFFFF : 16'(k);
    endfunction

    function automatic bit tb_slot(int h, int v);
        int ln;
        ln = (v == 805) ? 0 : v + 1;
        return ((v < 768) && (h % 4 == 0) && (h <= 1016)) || ((h == 1340) && (ln < 768));
    endfunction

    function automatic int tb_daddr(int h, int v);
        int ln;
        ln = (v == 805) ? 0 : v + 1;
        return (h == 1340) ? ln * 256 : v * 256 + h / 4 + 1;
    endfunction

    // One pixel clock: drive, check last cycle's registered pixel, push this cycle's expectation
    task automatic step(int h, int v, bit req, int wa, int wd, bit r);
        exp_t        e;
        bit          valid;
        logic [15:0] word;
        @(negedge clk);
        rst         = r;
        bus.hcount  = 11'(h);
        bus.vcount  = 10'(v);
        bus.wr_req  = req;
        bus.wr_addr = 18'(wa);
        bus.wr_data = 16'(wd);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (r) e = '0;
            chk("pixel_valid", int'(bus.pixel_valid), int'(e.v));
            chk("pixel", int'(bus.pixel), int'(e.p));
        end
        chk("we_in_slot", int'(bus.mem_we && tb_slot(h, v)), 0);
        if (tb_slot(h, v)) chk("disp_addr", int'(bus.mem_addr), tb_daddr(h, v));
        if (!bus.mem_we) chk("din_idle", int'(bus.mem_din), 0);
        if (bus.wr_ack) acks++;
        if (r) tb_synced = 1'b0;
        valid = (h < 1024) && (v < 768);
        e.v   = valid && !r;
        word  = gold(v * 256 + h / 4);
        e.p   = (e.v && tb_synced) ? 4'(word >> (4 * (h % 4))) : 4'd0;
        sb.push_back(e);
        if (h == 1343 && !r) tb_synced = 1'b1;
    endtask

    initial begin
        bus.hcount  = 11'd0;
        bus.vcount  = 10'd800;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 18'd5;
        bus.wr_data = 16'hFFFF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pixel", int'(bus.pixel), 0);
        chk("rst_valid", int'(bus.pixel_valid), 0);
        chk("rst_ack", int'(bus.wr_ack), 0);
        chk("rst_we", int'(bus.mem_we), 0);

        // Blank line 805 with a continuous writer: word 5 <= FFFF
        acks = 0;
        for (int h = 0; h < 1344; h++) begin
            step(h, 805, 1'b1, 5, 16'hFFFF, 1'b0);
            if (h == 1340) begin
                chk("ls_addr", int'(bus.mem_addr), 0);
                chk("ls_we", int'(bus.mem_we), 0);
            end
        end
        chk("blank_line_acks", acks, 671);
        wrote5 = 1'b1;

        // Active lines 0..2
        pv_count = 0;
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < 1344; h++) begin
                step(h, v, 1'b0, 0, 0, 1'b0);
                pv_count += int'(bus.pixel_valid);
                if (v == 0 && h >= 1 && h <= 8) chk("line0_px", int'(bus.pixel), int'(l0_exp[h-1]));
                if (v == 0 && h >= 21 && h <= 24) chk("word5_px", int'(bus.pixel), 15);
            end
        end
        chk("valid_count", pv_count, 3072);

        // Tail of line 9, then line 10 with a write that collides with a display slot
        for (int h = 1330; h < 1344; h++) step(h, 9, 1'b0, 0, 0, 1'b0);
        for (int h = 0; h < 1344; h++) begin
            step(h, 10, (h < 3), 100, 100, 1'b0);
            if (h == 0) chk("stall_we", int'(bus.mem_we), 0);
            if (h == 1) begin
                chk("wr_we", int'(bus.mem_we), 1);
                chk("wr_addr", int'(bus.mem_addr), 100);
                chk("wr_din", int'(bus.mem_din), 100);
                chk("wr_ack_early", int'(bus.wr_ack), 0);
            end
            if (h == 2) begin
                chk("wr_ack", int'(bus.wr_ack), 1);
                chk("ack_no_we", int'(bus.mem_we), 0);
            end
            if (h == 3) chk("ack_pulse", int'(bus.wr_ack), 0);
        end

        // Line 11: reset at hcount=500 with a write in flight
        for (int h = 0; h < 1344; h++) begin
            step(h, 11, (h == 499) || (h == 500), 200, 200, (h >= 500) && (h <= 503));
            if (h == 499) chk("pre_rst_we", int'(bus.mem_we), 1);
            if (h == 500) begin
                chk("rst_mid_ack", int'(bus.wr_ack), 0);
                chk("rst_mid_pixel", int'(bus.pixel), 0);
                chk("rst_mid_valid", int'(bus.pixel_valid), 0);
                chk("rst_mid_we", int'(bus.mem_we), 0);
                acks = 0;
            end
        end
        chk("no_ack_after_rst", acks, 0);

        // Line 12 resumes from the line-start prefetch
        for (int h = 0; h < 1344; h++) step(h, 12, 1'b0, 0, 0, 1'b0);
        step(0, 13, 1'b0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port frame-buffer BRAM between the display fetch path and one pixel-writer client (waveform/plot renderer).
- Display reads are time-slotted off the XVGA timing counters (1024x768, 1344x806 totals) and always win.
- The writer gets every remaining cycle through a req/ack handshake.
- The block unpacks 4 pixels per memory word and emits one pixel per vga_clock to the colour mapper.

Parameters:
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- H_TOTAL, 1344, pixels per line incl. blanking
- V_TOTAL, 806, lines per frame
- PIX_BITS, 4, bits per pixel
- ADDR_W, 18, word address width (V_ACTIVE*H_ACTIVE/4 words)

Ports:
- vga_clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- hcount  in  11  current pixel number from timing generator
- vcount  in  10  current line number from timing generator
- mem_addr  out  ADDR_W  BRAM address, combinational from slot decision
- mem_we  out  1  BRAM write enable
- mem_din  out  4*PIX_BITS  BRAM write data
- mem_dout  in  4*PIX_BITS  BRAM read data, valid the cycle after the address
- wr_req  in  1  writer request; hold with addr/data until wr_ack
- wr_addr  in  ADDR_W  writer word address
- wr_data  in  4*PIX_BITS  writer word data
- wr_ack  out  1  one-cycle pulse: write has been performed
- pixel  out  PIX_BITS  display pixel, registered
- pixel_valid  out  1  pixel lies in the active area, registered

Behaviour:
- Word layout: pixel x sits at bits [PIX_BITS*(x%4) +: PIX_BITS] of word (y*H_ACTIVE/4)+(x>>2).
- Display slot (disp_slot) is asserted when either condition holds:
  - vcount<V_ACTIVE, hcount[1:0]==0, hcount<=H_ACTIVE-8: read the next group (vcount*256)+(hcount>>2)+1.
  - hcount==H_TOTAL-4 with the next line active: read word line_next*256. line_next = 0 if vcount==V_TOTAL-1, else vcount+1; the next line is active when line_next<V_ACTIVE.
- During a display slot: mem_we=0 and mem_addr=the display address.
- next_word captures mem_dout at the end of the cycle after each display slot.
- cur_word loads from next_word at the end of the cycle where hcount[1:0]==3 and hcount<H_ACTIVE-1.
- cur_word also loads at the end of the cycle where hcount==H_TOTAL-1, taking the line-start word.
- pixel / pixel_valid are registered: they reflect the hcount/vcount of the previous cycle. Latency is 1 cycle, matching the registered blank from the timing generator.
  - pixel = cur_word slice hcount[1:0] when hcount<H_ACTIVE && vcount<V_ACTIVE; otherwise pixel=0 and pixel_valid=0.
- Writer FSM, two states:
  - W_IDLE: if wr_req && !disp_slot, drive mem_we=1, mem_addr=wr_addr, mem_din=wr_data, go to W_ACK. If disp_slot, stall in W_IDLE.
  - W_ACK: wr_ack=1 for exactly this cycle, no write, return to W_IDLE. Back-to-back requests therefore complete at most one per 2 cycles.
- mem_din=0 whenever mem_we=0.
- Worst-case writer wait during active video is 1 cycle. During blanking it is 0, except for the line-start slot.
- A write to a word that has already been prefetched is not visible until the next frame. No bypass is implemented.
- Reset (async) clears: cur_word, next_word, pixel, pixel_valid, wr_ack; FSM returns to W_IDLE; mem_we=0 while reset is high.
  - A write in flight is dropped with no ack; the writer must re-request.
  - If reset is released mid-line, pixels read 0 until the next line-start prefetch.

Test Plan:
- BRAM preloaded with word k = k[15:0]; run a full frame. Line 0 pixels 0..7 = 0,0,0,0,1,0,0,0; pixel_valid=1 for exactly 1024x768 cycles.
- Hold wr_req at hcount=0, vcount=10 (display slot). Write occurs at hcount=1 and wr_ack pulses at hcount=2; mem_we never coincides with a display slot.
- Continuous wr_req across a blanking line. wr_ack every 2nd cycle (672 acks per 1344-cycle blank line, minus the line-start slot).
- hcount=1340, vcount=805: mem_addr=0, mem_we=0. At hcount=0, vcount=0 the next-cycle pixel is word 0 nibble 0.
- Write 16'hFFFF to word 5 during vblank. Next frame line 0 pixels 20..23 = 4'hF.
- Assert reset at hcount=500 with a write pending. wr_ack=0, pixel=0, mem_we=0 immediately; after release the line resumes correctly from the next line start.
